// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit: owns PC and IR and steps the datapath through
// fetch, decode, execute and memory phases with a req/ready memory handshake.
module cpu_sequencer (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_run,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_ready,
   input  logic        i_nflag,
   input  logic        i_zflag,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [3:0]  o_sel_a,
   output logic [3:0]  o_sel_b,
   output logic [3:0]  o_dr,
   output logic        o_rw,
   output logic [4:0]  o_fs,
   output logic        o_mb,
   output logic [31:0] o_mb_data,
   output logic [7:0]  o_pc,
   output logic        o_mm,
   output logic        o_md,
   output logic        o_halted,
   output logic        o_illegal
);

   localparam int unsigned PC_W   = 8;
   localparam int unsigned IR_W   = 32;
   localparam int unsigned IMM_W  = 11;

   localparam logic [3:0] OPC_NOP     = 4'd0;
   localparam logic [3:0] OPC_ALU_REG = 4'd1;
   localparam logic [3:0] OPC_ALU_IMM = 4'd2;
   localparam logic [3:0] OPC_LD      = 4'd3;
   localparam logic [3:0] OPC_ST      = 4'd4;
   localparam logic [3:0] OPC_BRZ     = 4'd5;
   localparam logic [3:0] OPC_BRN     = 4'd6;
   localparam logic [3:0] OPC_JMP     = 4'd7;
   localparam logic [3:0] OPC_HALT    = 4'd8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t            state, state_nxt;
   logic [PC_W-1:0]   pc, pc_nxt;
   logic [IR_W-1:0]   ir, ir_nxt;
   logic [3:0]        opc;
   logic [PC_W-1:0]   imm8;

   assign opc       = ir[31:28];
   assign imm8      = ir[7:0];
   assign o_fs      = ir[27:23];
   assign o_dr      = ir[22:19];
   assign o_sel_a   = ir[18:15];
   assign o_sel_b   = ir[14:11];
   assign o_mb_data = {(IR_W-IMM_W)'(0), ir[IMM_W-1:0]};
   assign o_pc      = pc;

   // State, PC and IR registers
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state <= S_IDLE;
         pc    <= '0;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         ir    <= ir_nxt;
      end
   end

   // Next state, PC/IR updates and combinational strobes
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      ir_nxt    = ir;
      o_mem_req = 1'b0;
      o_mem_we  = 1'b0;
      o_rw      = 1'b0;
      o_mb      = 1'b0;
      o_mm      = 1'b0;
      o_md      = 1'b0;
      o_halted  = 1'b0;
      o_illegal = 1'b0;

      case (state)
         S_IDLE: begin
            if (i_run) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            o_mem_req = 1'b1;
            o_mm      = 1'b1;
            if (i_mem_ready) begin
               ir_nxt    = i_mem_rdata;
               pc_nxt    = pc + PC_W'(1);
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            state_nxt = S_FETCH;
            case (opc)
               OPC_NOP: ;
               OPC_ALU_REG: o_rw = 1'b1;
               OPC_ALU_IMM: begin
                  o_mb = 1'b1;
                  o_rw = 1'b1;
               end
               OPC_LD, OPC_ST: state_nxt = S_MEM;
               // Modulo-256 add of imm8 equals adding its sign extension
               OPC_BRZ: if (i_zflag) pc_nxt = pc + imm8;
               OPC_BRN: if (i_nflag) pc_nxt = pc + imm8;
               OPC_JMP: pc_nxt = imm8;
               OPC_HALT: state_nxt = S_HALT;
               default: o_illegal = 1'b1;
            endcase
         end
         S_MEM: begin
            o_mem_req = 1'b1;
            if (opc == OPC_LD) begin
               o_md = 1'b1;
               o_rw = i_mem_ready;
            end else begin
               o_mem_we = 1'b1;
            end
            if (i_mem_ready) state_nxt = S_FETCH;
         end
         S_HALT: begin
            o_halted = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: table of single-instruction vectors plus
// hand-written LD/ST wait-state, HALT and mid-fetch reset sequences.
module tb_cpu_sequencer;

   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic        i_run;
   logic [31:0] i_mem_rdata;
   logic        i_mem_ready;
   logic        i_nflag;
   logic        i_zflag;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [3:0]  o_sel_a;
   logic [3:0]  o_sel_b;
   logic [3:0]  o_dr;
   logic        o_rw;
   logic [4:0]  o_fs;
   logic        o_mb;
   logic [31:0] o_mb_data;
   logic [7:0]  o_pc;
   logic        o_mm;
   logic        o_md;
   logic        o_halted;
   logic        o_illegal;

   int total = 0;
   int bad   = 0;

   cpu_sequencer dut (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_run       (i_run),
      .i_mem_rdata (i_mem_rdata),
      .i_mem_ready (i_mem_ready),
      .i_nflag     (i_nflag),
      .i_zflag     (i_zflag),
      .o_mem_req   (o_mem_req),
      .o_mem_we    (o_mem_we),
      .o_sel_a     (o_sel_a),
      .o_sel_b     (o_sel_b),
      .o_dr        (o_dr),
      .o_rw        (o_rw),
      .o_fs        (o_fs),
      .o_mb        (o_mb),
      .o_mb_data   (o_mb_data),
      .o_pc        (o_pc),
      .o_mm        (o_mm),
      .o_md        (o_md),
      .o_halted    (o_halted),
      .o_illegal   (o_illegal)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] instr;
      logic        z;
      logic        n;
      logic        rw;
      logic        mb;
      logic        ill;
      logic [3:0]  dr;
      logic [31:0] mbd;
      logic [7:0]  pc_after;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[14];
      logic [7:0] pc_exp;

      vt[0]  = '{32'h21880005, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'h005, 8'h01};
      vt[1]  = '{32'h1011A000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 32'h000, 8'h02};
      vt[2]  = '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h000, 8'h03};
      vt[3]  = '{32'h70000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h010, 8'h10};
      vt[4]  = '{32'h500000FE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0FE, 8'h0F};
      vt[5]  = '{32'h70000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h010, 8'h10};
      vt[6]  = '{32'h500000FE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0FE, 8'h11};
      vt[7]  = '{32'h60000002, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h002, 8'h14};
      vt[8]  = '{32'h60000002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h002, 8'h15};
      vt[9]  = '{32'h500000FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0FF, 8'h15};
      vt[10] = '{32'hB0000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 32'h000, 8'h16};
      vt[11] = '{32'h700000FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0FF, 8'hFF};
      vt[12] = '{32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h000, 8'h00};
      vt[13] = '{32'hF0000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h000, 8'h01};

      i_rstn = 1'b0; i_run = 1'b0; i_mem_rdata = '0; i_mem_ready = 1'b0;
      i_nflag = 1'b0; i_zflag = 1'b0;
      repeat (2) tick();
      chk("rst_pc", 32'(o_pc), 32'h0);
      chk("rst_req", 32'(o_mem_req), 32'h0);
      chk("rst_halted", 32'(o_halted), 32'h0);
      i_rstn = 1'b1;
      i_mem_ready = 1'b1;
      tick();
      chk("idle_req", 32'(o_mem_req), 32'h0);
      chk("idle_pc", 32'(o_pc), 32'h0);
      i_run = 1'b1;
      tick();
      chk("run_req", 32'(o_mem_req), 32'h1);
      chk("run_mm", 32'(o_mm), 32'h1);
      chk("run_we", 32'(o_mem_we), 32'h0);
      chk("run_pc", 32'(o_pc), 32'h0);
      i_run = 1'b0;

      pc_exp = 8'h00;
      for (int i = 0; i < 14; i++) begin
         i_mem_rdata = vt[i].instr; i_mem_ready = 1'b1;
         i_zflag = vt[i].z; i_nflag = vt[i].n;
         #1;
         chk($sformatf("v%0d_fetch_req", i), 32'(o_mem_req), 32'h1);
         chk($sformatf("v%0d_fetch_pc", i), 32'(o_pc), 32'(pc_exp));
         tick();
         i_mem_ready = 1'b0;
         chk($sformatf("v%0d_dec_req", i), 32'(o_mem_req), 32'h0);
         chk($sformatf("v%0d_dec_rw", i), 32'(o_rw), 32'h0);
         tick();
         chk($sformatf("v%0d_ex_rw", i), 32'(o_rw), 32'(vt[i].rw));
         chk($sformatf("v%0d_ex_mb", i), 32'(o_mb), 32'(vt[i].mb));
         chk($sformatf("v%0d_ex_ill", i), 32'(o_illegal), 32'(vt[i].ill));
         chk($sformatf("v%0d_ex_dr", i), 32'(o_dr), 32'(vt[i].dr));
         chk($sformatf("v%0d_ex_mbd", i), o_mb_data, vt[i].mbd);
         tick();
         chk($sformatf("v%0d_next_pc", i), 32'(o_pc), 32'(vt[i].pc_after));
         chk($sformatf("v%0d_next_req", i), 32'(o_mem_req), 32'h1);
         chk($sformatf("v%0d_next_rw", i), 32'(o_rw), 32'h0);
         chk($sformatf("v%0d_next_ill", i), 32'(o_illegal), 32'h0);
         pc_exp = vt[i].pc_after;
      end

      // LD at PC 0x01, memory withholds ready for 3 MEM cycles (7 cycles total)
      i_mem_rdata = 32'h30328000; i_mem_ready = 1'b1;
      tick();
      i_mem_ready = 1'b0;
      tick();
      chk("ld_ex_rw", 32'(o_rw), 32'h0);
      chk("ld_ex_req", 32'(o_mem_req), 32'h0);
      tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("ld_w%0d_req", k), 32'(o_mem_req), 32'h1);
         chk($sformatf("ld_w%0d_mm", k), 32'(o_mm), 32'h0);
         chk($sformatf("ld_w%0d_md", k), 32'(o_md), 32'h1);
         chk($sformatf("ld_w%0d_rw", k), 32'(o_rw), 32'h0);
         chk($sformatf("ld_w%0d_we", k), 32'(o_mem_we), 32'h0);
         chk($sformatf("ld_w%0d_sa", k), 32'(o_sel_a), 32'h5);
         tick();
      end
      i_mem_ready = 1'b1;
      #1;
      chk("ld_rdy_rw", 32'(o_rw), 32'h1);
      chk("ld_rdy_md", 32'(o_md), 32'h1);
      chk("ld_rdy_dr", 32'(o_dr), 32'h6);
      i_mem_rdata = 32'h40011800;
      tick();
      chk("ld_done_mm", 32'(o_mm), 32'h1);
      chk("ld_done_md", 32'(o_md), 32'h0);
      chk("ld_done_rw", 32'(o_rw), 32'h0);
      chk("ld_done_pc", 32'(o_pc), 32'h02);

      // ST at PC 0x02 with two wait cycles in MEM
      tick();
      i_mem_ready = 1'b0;
      tick();
      chk("st_ex_rw", 32'(o_rw), 32'h0);
      tick();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("st_w%0d_req", k), 32'(o_mem_req), 32'h1);
         chk($sformatf("st_w%0d_we", k), 32'(o_mem_we), 32'h1);
         chk($sformatf("st_w%0d_mm", k), 32'(o_mm), 32'h0);
         chk($sformatf("st_w%0d_mb", k), 32'(o_mb), 32'h0);
         chk($sformatf("st_w%0d_rw", k), 32'(o_rw), 32'h0);
         chk($sformatf("st_w%0d_sb", k), 32'(o_sel_b), 32'h3);
         tick();
      end
      i_mem_ready = 1'b1;
      #1;
      chk("st_rdy_we", 32'(o_mem_we), 32'h1);
      chk("st_rdy_rw", 32'(o_rw), 32'h0);
      tick();
      i_mem_ready = 1'b0;
      chk("st_done_pc", 32'(o_pc), 32'h03);
      chk("st_done_we", 32'(o_mem_we), 32'h0);

      // FETCH wait: request and PC stay put, then HALT
      tick();
      chk("fw_req", 32'(o_mem_req), 32'h1);
      chk("fw_pc", 32'(o_pc), 32'h03);
      i_mem_rdata = 32'h80000000; i_mem_ready = 1'b1;
      tick();
      tick();
      tick();
      i_run = 1'b1;
      for (int k = 0; k < 20; k++) begin
         chk($sformatf("halt%0d_halted", k), 32'(o_halted), 32'h1);
         chk($sformatf("halt%0d_req", k), 32'(o_mem_req), 32'h0);
         tick();
      end
      chk("halt_pc", 32'(o_pc), 32'h04);

      // Reset, run a NOP, then assert reset asynchronously during a FETCH wait
      i_rstn = 1'b0;
      tick();
      i_rstn = 1'b1;
      i_run = 1'b1;
      tick();
      i_run = 1'b0;
      i_mem_rdata = 32'h0; i_mem_ready = 1'b1;
      tick();
      i_mem_ready = 1'b0;
      tick();
      tick();
      tick();
      chk("rw_req", 32'(o_mem_req), 32'h1);
      chk("rw_pc", 32'(o_pc), 32'h01);
      #3;
      i_rstn = 1'b0;
      #1;
      chk("arst_req", 32'(o_mem_req), 32'h0);
      chk("arst_we", 32'(o_mem_we), 32'h0);
      chk("arst_rw", 32'(o_rw), 32'h0);
      chk("arst_pc", 32'(o_pc), 32'h0);
      tick();
      i_rstn = 1'b1;
      tick();
      chk("post_rst_req", 32'(o_mem_req), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control unit that sequences the CPU datapath through fetch, decode, execute and memory phases. It owns the 8-bit program counter and the instruction register. It drives every datapath control input: register selects, write enable, function select, operand-B and address muxes, and load mux. It also runs a request/ready handshake with the shared instruction/data memory and consumes the datapath's registered N/Z flags for conditional branches.

## Interface
- No parameters; all widths are fixed by the datapath.
- i_clk  in  1  clock
- i_rstn  in  1  reset; asynchronous, active-low
- i_run  in  1  level; leaves IDLE when high
- i_mem_rdata  in  32  memory read data; instruction word during fetch, load data otherwise
- i_mem_ready  in  1  memory completes the current request this cycle
- i_nflag, i_zflag  in  1 each  datapath registered flags
- o_mem_req  out  1  memory request
- o_mem_we  out  1  write qualifier for o_mem_req
- o_sel_a, o_sel_b, o_dr  out  4 each  register-file selects and destination
- o_rw  out  1  register/flag write strobe
- o_fs  out  5  function select
- o_mb  out  1  selects immediate as operand B
- o_mb_data  out  32  immediate
- o_pc  out  8  program counter
- o_mm  out  1  1 = memory address from PC, 0 = from R[sel_a]
- o_md  out  1  1 = register write data from memory
- o_halted  out  1  high in HALT
- o_illegal  out  1  one-cycle pulse on an undefined opcode

## Operation
- IR fields:
  - opc = IR[31:28]
  - fs = IR[27:23]
  - dr = IR[22:19]
  - sa = IR[18:15]
  - sb = IR[14:11]
  - imm11 = IR[10:0]
  - imm8 = IR[7:0]
- o_sel_a, o_sel_b, o_dr and o_fs are driven from IR fields continuously.
- o_mb_data = zero-extended imm11.
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
- IDLE: all strobes low; go to FETCH when i_run=1.
- FETCH:
  - Drives o_mem_req=1, o_mm=1, o_mem_we=0.
  - Holds until i_mem_ready=1.
  - On that edge: IR <= i_mem_rdata, PC <= PC+1 (mod 256), go to DECODE.
- DECODE: one cycle, no strobes. Opcode classified; go to EXEC.
- EXEC, by opcode:
  - 0 NOP: no effect.
  - 1 ALU-reg: o_mb=0, o_rw=1 for one cycle.
  - 2 ALU-imm: o_mb=1, o_rw=1 for one cycle.
  - 3 LD: go to MEM.
  - 4 ST: go to MEM.
  - 5 BRZ: if i_zflag, PC <= PC + sign-extended imm8.
  - 6 BRN: same rule on i_nflag.
  - 7 JMP: PC <= imm8.
  - 8 HALT: go to HALT.
  - 9–15: o_illegal=1 for one cycle, otherwise NOP.
  - Every opcode except LD, ST and HALT returns to FETCH.
- MEM, LD:
  - Drives o_mem_req=1, o_mm=0, o_md=1.
  - o_rw=1 only in the cycle i_mem_ready=1; then go to FETCH.
- MEM, ST:
  - Drives o_mem_req=1, o_mem_we=1, o_mm=0.
  - Address is R[sa]; data is R[sb] (o_mb=0).
  - Go to FETCH on i_mem_ready.
- HALT: o_halted=1, all strobes low. Left only by reset.
- Branch arithmetic:
  - 8-bit, modulo 256.
  - Offset is relative to the already-incremented PC.
  - imm8=0xFF branches back to the branch instruction itself.
- The datapath's flags update only on o_rw, so a branch sees the flags of the last register-writing instruction.

## Timing
- Reset values:
  - State IDLE, PC=0, IR=0.
  - o_mem_req=0, o_mem_we=0, o_rw=0, o_mb=0, o_mm=0, o_md=0.
  - o_halted=0, o_illegal=0, o_pc=0.
- Reset is asynchronous. Asserting it mid-request drops o_mem_req and o_mem_we immediately; no partial register write occurs.
- Strobes are combinational from state and IR; o_rw is never asserted for more than one cycle per instruction.
- Latency with zero-wait memory (i_mem_ready high in the first request cycle):
  - ALU, branch, JMP, NOP: 3 cycles.
  - LD, ST: 4 cycles.
  - Each wait cycle adds one cycle to FETCH or MEM.
- o_mem_req stays high and its address/we stay stable until i_mem_ready is sampled high. i_mem_ready outside FETCH/MEM is ignored.
- i_run is sampled only in IDLE; deasserting it mid-program has no effect.
- PC wraps 0xFF -> 0x00 on fetch increment.

## Test plan
- Reset with i_run=0, then release: IDLE, o_pc=0, o_mem_req=0. Set i_run=1: o_mem_req=1 and o_mm=1 the next cycle.
- ALU-imm IR=0x2_08_?_03 form (opc=2, dr=1, imm11=5), zero-wait: o_rw high exactly in cycle 3, o_mb=1, o_mb_data=5, o_dr=1; PC 0->1.
- LD with i_mem_ready withheld 3 cycles in MEM: o_mem_req, o_mm=0 and o_md=1 held 3 cycles; o_rw only in the ready cycle; total 7 cycles.
- ST: o_mem_we=1 with o_mem_req until ready; o_rw never asserted.
- BRZ imm8=0xFE at PC=0x10: i_zflag=1 gives next fetch at 0x0F; i_zflag=0 gives 0x11. JMP imm8=0xFF then fetch at 0xFF, next sequential fetch at 0x00.
- Opcode 0xB: single o_illegal pulse, no o_rw. HALT: o_halted=1, o_mem_req=0 for 20 cycles. Reset asserted during FETCH wait: o_mem_req low asynchronously, PC=0.
